ram_read_streamer: RTL and testbench

Read-side sequencer placed directly downstream of the banked simple dual-port line RAM. It accepts a burst command (start line, start element, element count) and drives the RAM read address and element-select ports one element per cycle. It absorbs the RAM's one-cycle registered read latency and presents the elements as a valid/ready stream with last-marking, stalling reads under back-pressure so no element is lost.

---
 rtl/globalDefinitions.sv | 18 +
 rtl/ram_read_streamer_fifo.sv | 58 +++++
 rtl/ram_read_streamer.sv | 122 ++++++++++++
 tb/tb_ram_read_streamer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/globalDefinitions.sv
// Shared definitions for the line-RAM datapath: FSM state types and width helpers.
package globalDefinitions;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } readStreamState_t;

    // Ceiling log2, floored at 1 so a single-element line still gets a select port.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/ram_read_streamer_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide even when full.
module small_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_check:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    underflow_check: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/ram_read_streamer.sv
// Burst read sequencer for the banked line RAM: issues one element read per cycle and
// re-times the registered RAM output into a valid/ready stream with last-marking.
module ram_read_streamer
    import globalDefinitions::*;
#(
    parameter  int unsigned ADDR_WIDTH = 1,
    parameter  int unsigned WORD_SIZE  = 1,
    parameter  int unsigned WORDS      = 1,
    parameter  int unsigned LEN_WIDTH  = 16,
    localparam int unsigned ELM_W      = log2(WORDS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [ELM_W-1:0]           cmd_elm,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic [ADDR_WIDTH-1:0]      raddr,
    output logic [ELM_W-1:0]           raddrElm,
    input  logic [WORDS*WORD_SIZE-1:0] ram_q,
    output logic [WORD_SIZE-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       done
);

    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    readStreamState_t     state;
    readStreamState_t     next_state;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 inflight;
    logic                 inflight_last;
    logic                 rd_issue;
    logic                 accept;
    logic                 pop;
    logic                 last_read;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occupancy;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [WORD_SIZE:0]   fifo_head;

    assign accept    = cmd_valid && cmd_ready;
    assign pop       = out_valid && out_ready;
    assign last_read = (remaining == LEN_WIDTH'(1));
    // Reads in flight count against FIFO space so the RAM output never needs to be dropped.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[WORD_SIZE-1:0];
    assign out_last  = fifo_head[WORD_SIZE];

    always_comb begin
        next_state = state;
        rd_issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && cmd_len != '0) next_state = RUN;
            end
            RUN: begin
                rd_issue = (remaining != '0) && (occupancy <= (CNT_W + 1)'(2));
                if (rd_issue && last_read) next_state = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            raddr         <= '0;
            raddrElm      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= next_state;
            cmd_ready     <= (next_state == IDLE);
            inflight      <= rd_issue;
            inflight_last <= rd_issue && last_read;
            done          <= (accept && cmd_len == '0) || (pop && out_last);
            if (accept) begin
                raddr     <= cmd_addr;
                raddrElm  <= cmd_elm;
                remaining <= cmd_len;
            end else if (rd_issue) begin
                remaining <= remaining - LEN_WIDTH'(1);
                if (raddrElm == ELM_W'(WORDS - 1)) begin
                    raddrElm <= '0;
                    raddr    <= raddr + ADDR_WIDTH'(1);
                end else begin
                    raddrElm <= raddrElm + ELM_W'(1);
                end
            end
        end
    end

    small_sync_fifo #(
        .WIDTH (WORD_SIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({inflight_last, ram_q[WORD_SIZE-1:0]}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ram_read_streamer.sv
// Self-checking bench for ram_read_streamer: behavioural stream/address model plus directed pins.
module tb_ram_read_streamer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 elements per line, 16 lines
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_addr  = '0;
    logic [1:0]  cmd_elm   = '0;
    logic [7:0]  cmd_len   = '0;
    logic [3:0]  raddr;
    logic [1:0]  raddrElm;
    logic [31:0] ram_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;

    // Instance B: one element per line
    logic        b_cmd_valid = 1'b0;
    logic        b_cmd_ready;
    logic [3:0]  b_cmd_addr  = '0;
    logic [0:0]  b_cmd_elm   = '0;
    logic [7:0]  b_cmd_len   = '0;
    logic [3:0]  b_raddr;
    logic [0:0]  b_raddrElm;
    logic [7:0]  b_ram_q;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic        b_out_last;
    logic        b_done;

    ram_read_streamer #(.ADDR_WIDTH(4), .WORD_SIZE(8), .WORDS(4), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_elm(cmd_elm), .cmd_len(cmd_len), .raddr(raddr),
        .raddrElm(raddrElm), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    ram_read_streamer #(.ADDR_WIDTH(4), .WORD_SIZE(8), .WORDS(1), .LEN_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_addr(b_cmd_addr), .cmd_elm(b_cmd_elm), .cmd_len(b_cmd_len), .raddr(b_raddr),
        .raddrElm(b_raddrElm), .ram_q(b_ram_q), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .done(b_done)
    );

    function automatic logic [7:0] content(input int unsigned line, input int unsigned elm);
        return 8'((line * 4 + elm) * 37 + 11);
    endfunction

    function automatic logic [7:0] content1(input int unsigned line);
        return 8'(line * 53 + 7);
    endfunction

    // Registered RAM read; selected element lands in element 0, other lanes carry junk.
    always @(posedge clk) begin
        ram_q   <= {24'($urandom()), content(32'(raddr), 32'(raddrElm))};
        b_ram_q <= content1(32'(b_raddr));
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    bit ready_mode  = 1'b0;
    bit ready_force = 1'b1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Behavioural model: expected beats and expected read-address trajectory per burst.
    typedef struct packed { logic last; logic [7:0] data; } beat_t;
    beat_t        exp_q[$];
    logic [5:0]   pos_q[$];
    logic [7:0]   seen_q[$];
    int unsigned  hs_cyc[$];
    logic         done_exp      = 1'b0;
    logic         cmd_ready_exp = 1'b0;
    logic         rst_edge      = 1'b0;
    logic         busy          = 1'b0;
    logic         pos_pending   = 1'b0;
    logic [5:0]   last_pos      = '0;
    logic [5:0]   pending_start = '0;
    int           age           = -1;
    int unsigned  cyc           = 0;

    always @(negedge clk) begin : compare
        logic [5:0] cur;
        beat_t      b;
        cyc++;
        cur = {raddr, raddrElm};
        if (rst_edge) begin
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_raddr",     32'(cur),       32'd0);
            check("rst_out_data",  32'(out_data),  32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_last",  32'(out_last),  32'd0);
            check("rst_done",      32'(done),      32'd0);
        end else begin
            check("done",      32'(done),      32'(done_exp));
            check("cmd_ready", 32'(cmd_ready), 32'(cmd_ready_exp));
            if (pos_pending) begin
                check("raddr_load", 32'(cur), 32'(pending_start));
                pos_pending = 1'b0;
            end else if (cur != last_pos) begin
                if (pos_q.size() == 0) check("raddr_unexpected_move", 32'(cur), 32'(last_pos));
                else check("raddr_seq", 32'(cur), 32'(pos_q.pop_front()));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("out_valid_when_empty", 32'(out_valid), 32'd0);
                else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0].data));
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                end
            end
            if (age == 0 || age == 1) check("latency_early", 32'(out_valid), 32'd0);
            if (age == 2) check("latency_first", 32'(out_valid), 32'd1);
        end
        last_pos = cur;

        if (age >= 0) age = (age >= 2) ? -1 : age + 1;
        rst_edge = !rst_n;
        if (!rst_n) begin
            exp_q.delete();
            pos_q.delete();
            done_exp      = 1'b0;
            cmd_ready_exp = 1'b0;
            busy          = 1'b0;
            pos_pending   = 1'b0;
            age           = -1;
        end else begin
            done_exp = 1'b0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                hs_cyc.push_back(cyc);
                seen_q.push_back(out_data);
                if (b.last) begin
                    busy     = 1'b0;
                    done_exp = 1'b1;
                end
            end
            if (cmd_valid && cmd_ready_exp) begin
                pos_pending   = 1'b1;
                pending_start = {cmd_addr, cmd_elm};
                if (cmd_len == '0) done_exp = 1'b1;
                else begin
                    busy = 1'b1;
                    age  = 0;
                end
                for (int unsigned i = 0; i < 32'(cmd_len); i++) begin
                    int unsigned p;
                    p = 32'(cmd_elm) + i;
                    exp_q.push_back('{last: (i == 32'(cmd_len) - 1),
                                      data: content((32'(cmd_addr) + p / 4) % 16, p % 4)});
                    p = p + 1;
                    pos_q.push_back({4'((32'(cmd_addr) + p / 4) % 16), 2'(p % 4)});
                end
            end
            cmd_ready_exp = !busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] a, input logic [1:0] e, input logic [7:0] l);
        int unsigned t;
        logic acc;
        t = 0;
        cmd_addr = a; cmd_elm = e; cmd_len = l; cmd_valid = 1'b1;
        do begin
            acc = cmd_ready;
            tick();
            t++;
        end while (!acc && t < 300);
        cmd_valid = 1'b0;
        if (!acc) check("cmd_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 500) begin
            tick();
            t++;
        end
        if (busy || exp_q.size() != 0) check("idle_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned rel_cyc, n_after, first_after, last_after, t, k_done, k_last;
        logic [7:0]  b_data[$];
        logic        b_lasts[$];

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Straight burst across a line boundary, consumer always ready
        hs_cyc.delete(); seen_q.delete();
        send_cmd(4'd2, 2'd1, 8'd6);
        wait_idle();
        check("t1_beats", 32'(hs_cyc.size()), 32'd6);
        if (hs_cyc.size() == 6) begin
            check("t1_back_to_back", hs_cyc[5] - hs_cyc[0], 32'd5);
            check("t1_d0", 32'(seen_q[0]), 32'h58);
            check("t1_d3", 32'(seen_q[3]), 32'hC7);
            check("t1_d5", 32'(seen_q[5]), 32'h11);
        end

        // Same burst with a five-cycle consumer stall
        hs_cyc.delete(); seen_q.delete();
        send_cmd(4'd2, 2'd1, 8'd6);
        repeat (3) tick();
        ready_force = 1'b0;
        repeat (5) tick();
        ready_force = 1'b1;
        rel_cyc = cyc + 1;
        wait_idle();
        check("t2_beats", 32'(hs_cyc.size()), 32'd6);
        n_after = 0; first_after = 0; last_after = 0;
        foreach (hs_cyc[i]) begin
            if (hs_cyc[i] >= rel_cyc) begin
                if (n_after == 0) first_after = hs_cyc[i];
                last_after = hs_cyc[i];
                n_after++;
            end
        end
        check("t2_resume", first_after, rel_cyc);
        check("t2_back_to_back", last_after - first_after, n_after - 1);
        if (seen_q.size() == 6) check("t2_d5", 32'(seen_q[5]), 32'h11);

        // Wrap of both element and line address
        seen_q.delete();
        send_cmd(4'd15, 2'd3, 8'd3);
        wait_idle();
        check("t3_beats", 32'(seen_q.size()), 32'd3);
        if (seen_q.size() == 3) begin
            check("t3_d0", 32'(seen_q[0]), 32'h26);
            check("t3_d1", 32'(seen_q[1]), 32'h0B);
            check("t3_d2", 32'(seen_q[2]), 32'h30);
        end

        // Empty burst
        send_cmd(4'd7, 2'd2, 8'd0);
        check("t4_done",      32'(done),      32'd1);
        check("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t4_no_valid",  32'(out_valid), 32'd0);
        tick();
        check("t4_done_drop", 32'(done),      32'd0);
        check("t4_no_valid2", 32'(out_valid), 32'd0);

        // Reset in the middle of a burst, then a clean burst
        send_cmd(4'd9, 2'd2, 8'd10);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("t5_valid_in_rst", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        seen_q.delete();
        send_cmd(4'd0, 2'd0, 8'd2);
        wait_idle();
        check("t5_beats", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t5_d0", 32'(seen_q[0]), 32'h0B);
            check("t5_d1", 32'(seen_q[1]), 32'h30);
        end

        // Single-element lines on instance B
        b_cmd_addr = 4'd5; b_cmd_elm = 1'b0; b_cmd_len = 8'd4; b_cmd_valid = 1'b1;
        t = 0;
        while (!b_cmd_ready && t < 20) begin tick(); t++; end
        tick();
        b_cmd_valid = 1'b0;
        k_done = 99; k_last = 99;
        for (int unsigned k = 0; k < 12; k++) begin
            if (k < 4) begin
                check("b_raddr",    32'(b_raddr),    5 + k);
                check("b_raddrElm", 32'(b_raddrElm), 32'd0);
            end
            if (b_out_valid) begin
                b_data.push_back(b_out_data);
                b_lasts.push_back(b_out_last);
                if (b_out_last) k_last = k;
            end
            if (b_done && k_done == 99) k_done = k;
            tick();
        end
        check("b_beats", 32'(b_data.size()), 32'd4);
        if (b_data.size() == 4) begin
            check("b_d0", 32'(b_data[0]), 32'h10);
            check("b_d1", 32'(b_data[1]), 32'h45);
            check("b_d2", 32'(b_data[2]), 32'h7A);
            check("b_d3", 32'(b_data[3]), 32'hAF);
            check("b_last_pattern", 32'({b_lasts[0], b_lasts[1], b_lasts[2], b_lasts[3]}), 32'b0001);
        end
        check("b_done_timing", k_done, k_last + 1);

        // Randomised bursts under random back-pressure
        ready_mode = 1'b1;
        for (int unsigned n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_cmd(4'($urandom()), 2'($urandom()), 8'($urandom_range(0, 12)));
        end
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
